// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache block-fill controller
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLOCK_WORDS = 8;

    // Block offset within a 16-byte line; cleared to form the block base.
    localparam int                    OFFSET_BITS = 4;
    localparam logic [OFFSET_BITS-1:0] OFFSET_MASK = 4'hF;

endpackage

// File: rtl/word_counter.sv
// rtl/word_counter.sv - 3-bit word counter with enable, sync clear and terminal-count flag
module word_counter #(
    parameter logic [2:0] LAST = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] cnt,
    output logic       tc
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller: issues word reads and writes the block back
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic              write_tag_array
);

    localparam logic [2:0]        LAST_WORD  = 3'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK  = ~{{(ADDR_W-OFFSET_BITS){1'b0}}, OFFSET_MASK};

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              issue_done_q, issue_done_d;

    logic [2:0] issue_cnt;
    logic [2:0] rcv_cnt;
    logic       issue_tc;
    logic       rcv_tc;
    logic       in_fill;
    logic       miss_accept;
    logic       issue_en;
    logic       rcv_en;

    // The word itself goes straight to the data array; only its strobe matters here.
    logic unused_data;
    assign unused_data = ^memory_data;

    assign in_fill     = (state_q == FILL);
    // Gated with rst_n so the stall and the latch stay quiet while reset is held.
    assign miss_accept = rst_n && (state_q == IDLE) && miss_detected;
    assign issue_en    = in_fill && !issue_done_q;
    assign rcv_en      = in_fill && memory_data_valid;

    word_counter #(.LAST(LAST_WORD)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (miss_accept),
        .en    (issue_en),
        .cnt   (issue_cnt),
        .tc    (issue_tc)
    );

    word_counter #(.LAST(LAST_WORD)) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (miss_accept),
        .en    (rcv_en),
        .cnt   (rcv_cnt),
        .tc    (rcv_tc)
    );

    assign fsm_busy         = in_fill || miss_accept;
    assign mem_rd_en        = issue_en;
    assign memory_address   = base_q + ADDR_W'({issue_cnt, 1'b0});
    assign write_data_array = rcv_en;
    assign fill_address     = base_q + ADDR_W'({rcv_cnt, 1'b0});
    assign write_tag_array  = rcv_en && rcv_tc;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_done_d = issue_done_q;
        case (state_q)
            IDLE: begin
                if (miss_accept) begin
                    state_d      = FILL;
                    base_d       = miss_address & BASE_MASK;
                    issue_done_d = 1'b0;
                end
            end
            FILL: begin
                // The issue counter wraps after the last word; this flag stops further reads.
                if (issue_en && issue_tc) begin
                    issue_done_d = 1'b1;
                end
                if (write_tag_array) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issue_done_q <= issue_done_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm against a behavioural model
module tb_cache_fill_fsm;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic [DW-1:0] memory_data;
    logic          memory_data_valid;
    logic          fsm_busy;
    logic          mem_rd_en;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic [AW-1:0] fill_address;
    logic          write_tag_array;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_rd_en         (mem_rd_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .write_tag_array   (write_tag_array)
    );

    // Behavioural model: a fill is "base plus words issued / words received".
    bit m_fill;
    int m_base, m_issued, m_rcvd;
    int pend[$];
    int cyc = 0;
    int last_valid = -10;
    int lat_min = 4, lat_max = 4;
    bit gap_mode = 0;
    bit idle_noise = 0;

    int n_rd, n_wr, n_tag, tag_cyc, tag_beat, first_rd, first_wr, last_busy, min_addr, max_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_obs();
        n_rd = 0; n_wr = 0; n_tag = 0; tag_cyc = -1; tag_beat = -1;
        first_rd = -1; first_wr = -1; last_busy = -1;
        min_addr = 'hFFFFF; max_addr = -1;
    endtask

    task automatic step(input bit miss, input int addr);
        bit v;
        bit e_busy, e_rd, e_wr, e_tag;
        int t;
        @(negedge clk);
        v = 0;
        if (pend.size() > 0 && pend[0] <= cyc && (!gap_mode || cyc - last_valid >= 2)) begin
            v = 1;
            void'(pend.pop_front());
            last_valid = cyc;
        end else if (idle_noise && !m_fill && $urandom_range(0, 2) == 0) begin
            v = 1;
        end
        miss_detected     = miss;
        miss_address      = addr[AW-1:0];
        memory_data_valid = v;
        memory_data       = DW'($urandom);
        #1;
        e_busy = m_fill || miss;
        e_rd   = m_fill && (m_issued < BW);
        e_wr   = m_fill && v;
        e_tag  = e_wr && (m_rcvd == BW - 1);
        check("fsm_busy", fsm_busy, e_busy);
        check("mem_rd_en", mem_rd_en, e_rd);
        check("write_data_array", write_data_array, e_wr);
        check("write_tag_array", write_tag_array, e_tag);
        if (e_rd) check("memory_address", memory_address, (m_base + 2 * m_issued) % 65536);
        if (e_wr) check("fill_address", fill_address, (m_base + 2 * m_rcvd) % 65536);

        if (mem_rd_en === 1'b1) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            if (int'(memory_address) < min_addr) min_addr = int'(memory_address);
            if (int'(memory_address) > max_addr) max_addr = int'(memory_address);
        end
        if (write_data_array === 1'b1) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (write_tag_array === 1'b1) begin
            n_tag++;
            tag_cyc  = cyc;
            tag_beat = n_wr;
        end
        if (fsm_busy === 1'b1) last_busy = cyc;

        if (!m_fill && miss) begin
            m_fill = 1; m_base = addr & 'hFFF0; m_issued = 0; m_rcvd = 0;
        end else if (m_fill) begin
            if (e_rd) begin
                t = cyc + int'($urandom_range(lat_min, lat_max));
                if (pend.size() > 0 && t < pend[$]) t = pend[$];
                pend.push_back(t);
                m_issued++;
            end
            if (e_wr) begin
                m_rcvd++;
                if (m_rcvd == BW) m_fill = 0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        miss_detected = 1'b1;
        miss_address = AW'($urandom);
        memory_data_valid = 1'b1;
        #1;
        check("rst_busy", fsm_busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr", write_data_array, 0);
        check("rst_tag", write_tag_array, 0);
        check("rst_mem_addr", memory_address, 0);
        check("rst_fill_addr", fill_address, 0);
        @(negedge clk);
        #1;
        check("rst_busy_hold", fsm_busy, 0);
        check("rst_wr_hold", write_data_array, 0);
        m_fill = 0; m_base = 0; m_issued = 0; m_rcvd = 0;
        pend.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        miss_detected = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic run_fill(input int addr, input bit hold, input string tag);
        clr_obs();
        step(1'b1, addr);
        for (int k = 0; k < 300 && m_fill; k++) begin
            step(hold ? 1'b1 : bit'($urandom_range(0, 1)), int'($urandom));
        end
        check({tag, "_timeout"}, m_fill, 0);
        check({tag, "_reads"}, n_rd, BW);
        check({tag, "_writes"}, n_wr, BW);
        check({tag, "_tags"}, n_tag, 1);
        check({tag, "_tag_beat"}, tag_beat, BW);
    endtask

    initial begin
        rst_n = 1'b0;
        miss_detected = 1'b0;
        miss_address = '0;
        memory_data = '0;
        memory_data_valid = 1'b0;
        m_fill = 0;
        clr_obs();
        do_reset();

        // Fixed latency 4: reads in cycles 1-8, writes 5-12, tag in 12, idle in 13.
        lat_min = 4; lat_max = 4;
        clr_obs();
        cyc = 0;
        step(1'b1, 'h1236);
        for (int k = 0; k < 13; k++) step(1'b0, 0);
        check("s1_reads", n_rd, 8);
        check("s1_writes", n_wr, 8);
        check("s1_tags", n_tag, 1);
        check("s1_first_rd", first_rd, 1);
        check("s1_first_wr", first_wr, 5);
        check("s1_tag_cycle", tag_cyc, 12);
        check("s1_last_busy", last_busy, 12);
        check("s1_min_addr", min_addr, 'h1230);
        check("s1_max_addr", max_addr, 'h123E);

        // Top-of-space block must not carry out of the block.
        lat_min = 1; lat_max = 5;
        run_fill('hFFFA, 1'b0, "s2");
        check("s2_min_addr", min_addr, 'hFFF0);
        check("s2_max_addr", max_addr, 'hFFFE);

        // Miss held high for the whole fill, then a new miss straight after.
        run_fill('h0040, 1'b1, "s3");
        check("s3_min_addr", min_addr, 'h0040);
        check("s3_max_addr", max_addr, 'h004E);
        run_fill('h0086, 1'b0, "s3b");
        check("s3b_min_addr", min_addr, 'h0080);

        // Reset after the third data beat, then a clean fill.
        clr_obs();
        step(1'b1, 'h1000);
        for (int k = 0; k < 100 && n_wr < 3; k++) step(1'b0, 0);
        check("s4_beats_before_rst", n_wr, 3);
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b0, 0);
        check("s4_no_tag", n_tag, 0);
        run_fill('h0100, 1'b0, "s4");
        check("s4_min_addr", min_addr, 'h0100);

        // Stray valids while idle.
        idle_noise = 1;
        clr_obs();
        for (int k = 0; k < 20; k++) step(1'b0, int'($urandom));
        check("s5_idle_writes", n_wr, 0);
        check("s5_idle_busy", last_busy, -1);
        idle_noise = 0;

        // Valid every other cycle.
        gap_mode = 1; lat_min = 1; lat_max = 1; last_valid = -10;
        run_fill('h2468, 1'b0, "s6");
        gap_mode = 0;

        // Random addresses, latencies and spurious misses.
        lat_min = 1; lat_max = 6;
        idle_noise = 1;
        for (int f = 0; f < 15; f++) begin
            run_fill(int'($urandom), bit'($urandom_range(0, 1)), "rnd");
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
